// File: rtl/alu_pkg.sv
// Shared constants and issue bundle for the ALU issue stage.
// Used by alu_issue_stage and its testbench.
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SRA = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] OPCODE_OPIMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [2:0]      ctrl;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } issue_t;

endpackage

// File: rtl/alu_issue_stage_skid_buffer.sv
// Two-entry valid/ready buffer: output register plus one skid entry.
// in_ready_o comes straight from a flop, never from out_ready_i.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         out_vld_q, out_vld_d;
  logic [W-1:0] out_q, out_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] skid_q, skid_d;
  logic         acc;
  logic         load;

  always_comb begin
    acc        = in_valid_i && !skid_vld_q;
    load       = !out_vld_q || out_ready_i;
    out_vld_d  = out_vld_q;
    out_d      = out_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    if (load) begin
      // a full skid entry blocks the input, so only one source loads
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = acc;
        if (acc) out_d = in_data_i;
      end
    end else if (acc) begin
      skid_vld_d = 1'b1;
      skid_d     = in_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_q      <= out_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready_o  = !skid_vld_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = out_q;

endmodule

// File: rtl/alu_issue_stage.sv
// RV32I ALU decode/issue stage feeding the ALU through a skid buffer.
// Define ALU_ISSUE_FWD_EN to enable writeback forwarding.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            fwd_we,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [2:0]      out_ctrl,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1f, rs2f, rdf;
  logic [XLEN-1:0] v1, v2, op1, op2, imm, shamt;
  logic            r_base, r_alt, is_imm, legal;
  issue_t          dec, ob;

  assign opc   = in_instr[6:0];
  assign rdf   = in_instr[11:7];
  assign f3    = in_instr[14:12];
  assign rs1f  = in_instr[19:15];
  assign rs2f  = in_instr[24:20];
  assign f7    = in_instr[31:25];
  assign imm   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign shamt = {27'b0, in_instr[24:20]};

`ifdef ALU_ISSUE_FWD_EN
  logic hit1, hit2;
  assign hit1 = fwd_we && (fwd_rd != 5'd0) && (fwd_rd == rs1f);
  assign hit2 = fwd_we && (fwd_rd != 5'd0) && (fwd_rd == rs2f);
  assign v1   = hit1 ? fwd_data : in_rs1_data;
  assign v2   = hit2 ? fwd_data : in_rs2_data;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_we, fwd_rd, fwd_data};
  assign v1 = in_rs1_data;
  assign v2 = in_rs2_data;
`endif

  assign op1 = (rs1f == 5'd0) ? '0 : v1;
  assign op2 = (rs2f == 5'd0) ? '0 : v2;

  assign r_base = (opc == OPCODE_OP) && (f7 == F7_BASE);
  assign r_alt  = (opc == OPCODE_OP) && (f7 == F7_ALT);
  assign is_imm = (opc == OPCODE_OPIMM);

  always_comb begin
    legal    = 1'b1;
    dec      = '0;
    dec.a    = op1;
    dec.b    = op2;
    dec.rd   = rdf;
    unique case (1'b1)
      r_base: begin
        unique case (f3)
          F3_ADD: dec.ctrl = ALU_ADD;
          F3_SLT: dec.ctrl = ALU_SLT;
          F3_OR:  dec.ctrl = ALU_OR;
          F3_SLL: begin
            dec.ctrl = ALU_SLL;
            dec.b    = {27'b0, op2[4:0]};
          end
          F3_SR: begin
            dec.ctrl = ALU_SRL;
            dec.b    = {27'b0, op2[4:0]};
          end
          default: legal = 1'b0;
        endcase
      end
      r_alt: begin
        unique case (f3)
          F3_ADD: dec.ctrl = ALU_SUB;
          F3_SR: begin
            dec.ctrl = ALU_SRA;
            dec.b    = {27'b0, op2[4:0]};
          end
          default: legal = 1'b0;
        endcase
      end
      is_imm: begin
        dec.b = imm;
        unique case (f3)
          F3_ADD: dec.ctrl = ALU_ADD;
          F3_SLT: dec.ctrl = ALU_SLT;
          F3_OR:  dec.ctrl = ALU_OR;
          F3_SLL: begin
            dec.ctrl = ALU_SLL;
            dec.b    = shamt;
            legal    = (f7 == F7_BASE);
          end
          F3_SR: begin
            dec.ctrl = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.b    = shamt;
            legal    = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.a    = '0;
      dec.b    = '0;
      dec.ctrl = ALU_ADD;
    end
    dec.illegal = !legal;
    dec.we      = legal && (rdf != 5'd0);
  end

  skid_buffer #(.W($bits(issue_t))) u_skid (
    .clk        (clk),
    .rst_n      (reset_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (dec),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (ob)
  );

  assign out_a       = ob.a;
  assign out_b       = ob.b;
  assign out_ctrl    = ob.ctrl;
  assign out_rd      = ob.rd;
  assign out_we      = ob.we;
  assign out_illegal = ob.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized scoreboard bench for alu_issue_stage.
// Honors ALU_ISSUE_FWD_EN the same way the design does.
module tb_alu_issue_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_rs1_data, in_rs2_data;
  logic        fwd_we;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [2:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic        out_we, out_illegal;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  issue_t q[$];

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .fwd_we(fwd_we),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_ctrl(out_ctrl),
    .out_rd(out_rd), .out_we(out_we),
    .out_illegal(out_illegal)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src(input logic [4:0] f,
                                      input logic [31:0] d,
                                      input logic fwe,
                                      input logic [4:0] frd,
                                      input logic [31:0] fd);
    if (f == 0) return 0;
`ifdef ALU_ISSUE_FWD_EN
    if (fwe && frd != 0 && frd == f) return fd;
`endif
    return d;
  endfunction

  // What the ALU should be asked to do, mnemonic by mnemonic
  function automatic issue_t ref_model(input logic [31:0] ins,
                                       input logic [31:0] r1, r2,
                                       input logic fwe,
                                       input logic [4:0] frd,
                                       input logic [31:0] fd);
    issue_t e;
    int code, f3, f7;
    logic [31:0] s1, s2, bv;
    s1 = src(ins[19:15], r1, fwe, frd, fd);
    s2 = src(ins[24:20], r2, fwe, frd, fd);
    f3 = int'(ins[14:12]);
    f7 = int'(ins[31:25]);
    code = -1;
    bv = 0;
    if (ins[6:0] == 7'h33) begin
      if (f7 == 0) begin
        if (f3 == 0) code = 0;
        if (f3 == 1) code = 1;
        if (f3 == 2) code = 2;
        if (f3 == 5) code = 5;
        if (f3 == 6) code = 6;
      end else if (f7 == 32) begin
        if (f3 == 0) code = 3;
        if (f3 == 5) code = 4;
      end
      bv = (code == 1 || code == 4 || code == 5) ? s2 % 32 : s2;
    end else if (ins[6:0] == 7'h13) begin
      bv = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 0) code = 0;
      if (f3 == 2) code = 2;
      if (f3 == 6) code = 6;
      if (f3 == 1 && f7 == 0) code = 1;
      if (f3 == 5 && f7 == 0) code = 5;
      if (f3 == 5 && f7 == 32) code = 4;
      if (f3 == 1 || f3 == 5) bv = 32'(ins[24:20]);
    end
    e = '0;
    e.rd = ins[11:7];
    if (code < 0) begin
      e.illegal = 1'b1;
    end else begin
      e.a    = s1;
      e.b    = bv;
      e.ctrl = 3'(code);
      e.we   = (ins[11:7] != 0);
    end
    return e;
  endfunction

  task automatic check_state();
    chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_a", out_a, q[0].a);
      chk("out_b", out_b, q[0].b);
      chk("out_ctrl", 32'(out_ctrl), 32'(q[0].ctrl));
      chk("out_rd", 32'(out_rd), 32'(q[0].rd));
      chk("out_we", 32'(out_we), 32'(q[0].we));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].illegal));
    end
  endtask

  // Drive one cycle of stimulus; return at the following negedge
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [31:0] r1, r2,
                      input logic ordy, input logic fwe,
                      input logic [4:0] frd,
                      input logic [31:0] fd);
    bit take, give;
    in_valid = v; in_instr = ins;
    in_rs1_data = r1; in_rs2_data = r2;
    out_ready = ordy;
    fwd_we = fwe; fwd_rd = frd; fwd_data = fd;
    take = v && (q.size() < 2);
    give = ordy && (q.size() > 0);
    if (give) void'(q.pop_front());
    if (take) begin
      q.push_back(ref_model(ins, r1, r2, fwe, frd, fd));
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 5'd0, 32'h0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4) w[6:0] = 7'h33;
    else if (k < 8) w[6:0] = 7'h13;
    k = $urandom_range(0, 3);
    if (k < 2) w[31:25] = 7'h00;
    else if (k == 2) w[31:25] = 7'h20;
    w[19:15] = 5'($urandom_range(0, 3));
    w[24:20] = 5'($urandom_range(0, 3));
    w[11:7]  = 5'($urandom_range(0, 7));
    return w;
  endfunction

  initial begin
    reset_n = 1'b0;
    in_valid = 0; in_instr = 0; in_rs1_data = 0; in_rs2_data = 0;
    out_ready = 0; fwd_we = 0; fwd_rd = 0; fwd_data = 0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_a", out_a, 32'd0);
    chk("rst_out_b", out_b, 32'd0);
    chk("rst_fields",
        32'({out_ctrl, out_rd, out_we, out_illegal}), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    step(1, 32'h402081B3, 32'd10, 32'd3, 1, 0, 0, 0);
    chk("sub_ctrl", 32'(out_ctrl), 32'd3);
    chk("sub_a", out_a, 32'd10);
    chk("sub_b", out_b, 32'd3);
    chk("sub_rd", 32'(out_rd), 32'd3);
    chk("sub_we", 32'(out_we), 32'd1);

    step(1, 32'h40435293, 32'h80000000, 32'd77, 1, 0, 0, 0);
    chk("srai_ctrl", 32'(out_ctrl), 32'd4);
    chk("srai_b", out_b, 32'd4);
    chk("srai_a", out_a, 32'h80000000);

    step(1, 32'h003110B3, 32'd1, 32'h25, 1, 0, 0, 0);
    chk("sll_b", out_b, 32'd5);
    chk("sll_ctrl", 32'(out_ctrl), 32'd1);

    step(1, 32'h0020C1B3, 32'd12, 32'd34, 1, 0, 0, 0);
    chk("xor_illegal", 32'(out_illegal), 32'd1);
    chk("xor_we", 32'(out_we), 32'd0);
    chk("xor_ctrl", 32'(out_ctrl), 32'd0);
    chk("xor_a", out_a, 32'd0);

    step(1, 32'h00708013, 32'd5, 32'd0, 1, 0, 0, 0);
    chk("addi_x0_we", 32'(out_we), 32'd0);
    chk("addi_x0_b", out_b, 32'd7);

    idle(1'b1);
    n_acc = 0;
    for (int i = 0; i < 3; i++)
      step(1, 32'h002083B3, 32'(100 + i), 32'd0, 0, 0, 0, 0);
    chk("stall_accepted", 32'(n_acc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_hold_a", out_a, 32'd100);
    idle(1'b1);
    chk("drain1_a", out_a, 32'd101);
    chk("drain1_in_ready", 32'(in_ready), 32'd1);
    idle(1'b1);
    chk("drain2_valid", 32'(out_valid), 32'd0);

    step(1, 32'h00108233, 32'd5, 32'd5, 1, 1, 5'd1, 32'd99);
`ifdef ALU_ISSUE_FWD_EN
    chk("fwd_a", out_a, 32'd99);
    chk("fwd_b", out_b, 32'd99);
`else
    chk("nofwd_a", out_a, 32'd5);
    chk("nofwd_b", out_b, 32'd5);
`endif

    step(1, 32'h002083B3, 32'd1, 32'd2, 0, 0, 0, 0);
    step(1, 32'h002083B3, 32'd3, 32'd4, 0, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_a", out_a, 32'd0);
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 3) != 0), rand_instr(),
           $urandom, $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), $urandom);
    for (int i = 0; i < 4; i++) idle(1'b1);
    chk("final_empty", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
